// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: feeds one shared 1-bit full adder LSB-first and
// returns the WIDTH-bit sum plus carry-out over a valid/ready handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             busy,
  output logic             add_a,
  output logic             add_b,
  output logic             add_ci,
  input  logic             add_sum,
  input  logic             add_co
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CNTW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Drop the operation; result registers keep whatever they held.
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= in_a;
          b_sr  <= in_b;
          carry <= in_ci;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          carry  <= add_co;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // New sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
          sum_sr <= (sum_sr >> 1) | (WIDTH'(add_sum) << (WIDTH - 1));
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign add_a    = (state == RUN) & a_sr[0];
  assign add_b    = (state == RUN) & b_sr[0];
  assign add_ci   = (state == RUN) & carry;
  assign out_sum  = sum_sr;
  assign out_co   = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Random + directed bench for serial_add_ctrl (WIDTH=8 and WIDTH=1) against
// an a+b+ci reference, with the shared full adder modelled here.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst, abort, in_valid, in_ready, in_ci, out_valid, out_ready, out_co, busy;
  logic [7:0] in_a, in_b, out_sum;
  logic       add_a, add_b, add_ci, add_sum, add_co;

  logic       abort1, in_valid1, in_ready1, in_ci1, out_valid1, out_ready1, out_co1, busy1;
  logic [0:0] in_a1, in_b1, out_sum1;
  logic       add_a1, add_b1, add_ci1, add_sum1, add_co1;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  assign add_sum  = add_a ^ add_b ^ add_ci;
  assign add_co   = (add_a & add_b) | (add_a & add_ci) | (add_b & add_ci);
  assign add_sum1 = add_a1 ^ add_b1 ^ add_ci1;
  assign add_co1  = (add_a1 & add_b1) | (add_a1 & add_ci1) | (add_b1 & add_ci1);

  serial_add_ctrl #(.WIDTH(8), .CNTW(4)) u8 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co));

  serial_add_ctrl #(.WIDTH(1), .CNTW(1)) u1 (
    .clk(clk), .rst(rst), .abort(abort1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_co(out_co1), .busy(busy1), .add_a(add_a1), .add_b(add_b1),
    .add_ci(add_ci1), .add_sum(add_sum1), .add_co(add_co1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // One operation on the WIDTH=8 instance; hold = cycles of back-pressure,
  // abort_at = bit index at which to cancel (-1 for none).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input int hold, input int abort_at);
    logic [8:0] r;
    int         c;
    r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    wait_ready();
    in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      c = ((int'(a) & ((1 << k) - 1)) + (int'(b) & ((1 << k) - 1)) + int'(ci)) >> k;
      chk("add_a", add_a, a[k]);
      chk("add_b", add_b, b[k]);
      chk("add_ci", add_ci, c & 1);
      chk("run_busy", busy, 1);
      chk("run_out_valid", out_valid, 0);
      chk("run_in_ready", in_ready, 0);
      if (abort_at == k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        return;
      end
    end
    @(negedge clk);
    chk("done_out_valid", out_valid, 1);
    chk("done_sum", out_sum, r[7:0]);
    chk("done_co", out_co, r[8]);
    chk("done_add_a", add_a, 0);
    chk("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum", out_sum, r[7:0]);
      chk("hold_co", out_co, r[8]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("xfer_out_valid", out_valid, 0);
    chk("xfer_in_ready", in_ready, 1);
    chk("xfer_busy", busy, 0);
    chk("xfer_sum_held", out_sum, r[7:0]);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_co"}, out_co, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_add"}, {add_a, add_b, add_ci}, 0);
  endtask

  initial begin
    int        qa[$], qb[$], qc[$];
    int        cyc, last_acc, n, ea, eb, ec;
    logic [8:0] r;
    logic [1:0] r1;

    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b0;
    abort1 = 1'b0; in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_ci1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");
    chk("reset_w1_in_ready", in_ready1, 1);
    chk("reset_w1_out_valid", out_valid1, 0);

    // Directed cases
    run_op(8'h5A, 8'h33, 1'b0, 0, -1);
    run_op(8'hFF, 8'h01, 1'b0, 0, -1);
    run_op(8'hFF, 8'h00, 1'b1, 0, -1);
    run_op(8'h80, 8'h80, 1'b1, 0, -1);
    run_op(8'hC3, 8'h7E, 1'b1, 20, -1);
    run_op(8'h21, 8'h9F, 1'b0, 0, -1);

    // in_valid held high with changing operands: only accept-edge values count
    in_valid = 1'b1; out_ready = 1'b1; cyc = 0; last_acc = -1;
    for (int i = 0; i < 62; i++) begin
      if (out_valid === 1'b1) begin
        chk("cont_queue", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
          chk("cont_result", {out_co, out_sum}, ea + eb + ec);
        end
      end
      if (i < 50) begin
        in_a = 8'($urandom); in_b = 8'($urandom); in_ci = 1'($urandom);
        if (in_ready === 1'b1) begin
          qa.push_back(in_a); qb.push_back(in_b); qc.push_back(in_ci);
          if (last_acc >= 0) chk("cont_spacing", cyc - last_acc, 10);
          last_acc = cyc;
        end
      end else in_valid = 1'b0;
      cyc++;
      @(negedge clk);
    end
    chk("cont_drained", qa.size(), 0);

    // Abort at bit 3, then a normal operation
    run_op(8'h77, 8'h11, 1'b1, 0, 3);
    chk("abort_no_valid", out_valid, 0);
    run_op(8'h12, 8'h34, 1'b0, 0, -1);

    // Reset during RUN
    wait_ready();
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_ci = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("rst_run");

    // Reset during DONE
    wait_ready();
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_ci = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_done_reached", out_valid, 1);
    chk("rst_done_sum", out_sum, 8'h47);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("rst_done");

    // Random regression, WIDTH=8
    for (int i = 0; i < 600; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1);

    // Random regression, WIDTH=1
    out_ready1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      chk("w1_in_ready", in_ready1, 1);
      in_valid1 = 1'b1; in_a1 = 1'($urandom); in_b1 = 1'($urandom); in_ci1 = 1'($urandom);
      r1 = {1'b0, in_a1} + {1'b0, in_b1} + {1'b0, in_ci1};
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("w1_add", {add_a1, add_b1, add_ci1}, {in_a1, in_b1, in_ci1});
      chk("w1_busy", busy1, 1);
      chk("w1_run_valid", out_valid1, 0);
      @(negedge clk);
      chk("w1_out_valid", out_valid1, 1);
      chk("w1_result", {out_co1, out_sum1}, r1);
      @(negedge clk);
    end

    r = 9'd0;
    chk("final_idle", {busy, busy1, out_valid, out_valid1}, {4{r[0]}});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
